// File: rtl/ecc_scrub_scheduler.sv
// ecc_scrub_scheduler: shares the SECDED ECC port between a host and a background scrubber.
// Optional uncorrectable-error address log is enabled by defining ECC_SCRUB_ERRLOG_EN.
module ecc_scrub_scheduler #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int ADDR_STEP    = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ready,
  output logic                  ecc_req,
  output logic                  ecc_we,
  output logic [ADDR_WIDTH-1:0] ecc_addr,
  output logic [DATA_WIDTH-1:0] ecc_wdata,
  input  logic [DATA_WIDTH-1:0] ecc_rdata,
  input  logic                  ecc_ready,
  input  logic                  ecc_single_error,
  input  logic                  ecc_double_error,
  input  logic                  scrub_en,
  input  logic [15:0]           scrub_interval,
  input  logic [ADDR_WIDTH-1:0] scrub_base,
  input  logic [ADDR_WIDTH-1:0] scrub_limit,
  output logic                  scrub_busy,
  output logic                  pass_done,
  output logic [15:0]           corr_count,
  output logic [15:0]           uncorr_count,
  output logic [ADDR_WIDTH-1:0] last_err_addr,
  output logic                  uncorr_irq
`ifdef ECC_SCRUB_ERRLOG_EN
  ,
  input  logic                  errlog_pop,
  output logic                  errlog_valid,
  output logic [ADDR_WIDTH-1:0] errlog_addr
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    HOST,
    SCR_RD,
    SCR_CHK,
    SCR_WB
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] scrub_addr_q;
  logic [15:0]           intv_q;
  logic                  pending_q;
  logic [15:0]           starve_q;
  logic                  en_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pass_done_q;
  logic [15:0]           corr_q;
  logic [15:0]           uncorr_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  irq_q;

  logic                  en_rise;
  logic                  en_fall;
  logic                  busy;
  logic                  scrub_go;
  logic                  starved;
  logic                  wrap;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign en_rise  = scrub_en && !en_q;
  assign en_fall  = !scrub_en && en_q;
  assign busy     = (state_q == SCR_RD) || (state_q == SCR_CHK)
                 || (state_q == SCR_WB);
  assign scrub_go = pending_q && scrub_en;
  assign starved  = scrub_go && (starve_q >= 16'(STARVE_LIMIT));
  assign wrap     = scrub_addr_q >= scrub_limit;
  assign addr_nxt = wrap ? scrub_base
                         : scrub_addr_q + ADDR_WIDTH'(ADDR_STEP);

  // Interval timer raises a pending scrub; disabling the engine drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      intv_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      en_q <= scrub_en;
      if (!scrub_en) begin
        pending_q <= 1'b0;
      end else if (en_rise) begin
        intv_q <= scrub_interval;
      end else if (!busy) begin
        if (intv_q == 16'd0) begin
          pending_q <= 1'b1;
          intv_q    <= scrub_interval;
        end else begin
          intv_q <= intv_q - 16'd1;
        end
      end
      if (state_q == SCR_RD && ecc_ready) pending_q <= 1'b0;
    end
  end

  // Arbitration FSM, scrub address walk, error counters and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      scrub_addr_q <= '0;
      starve_q     <= '0;
      data_q       <= '0;
      pass_done_q  <= 1'b0;
      corr_q       <= '0;
      uncorr_q     <= '0;
      last_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      if (en_rise && !busy) scrub_addr_q <= scrub_base;
      if (en_fall) irq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (host_req && !starved) begin
            state_q <= HOST;
          end else if (scrub_go) begin
            state_q  <= SCR_RD;
            starve_q <= '0;
          end
        end
        HOST: begin
          if (pending_q && starve_q != 16'hFFFF)
            starve_q <= starve_q + 16'd1;
          if (ecc_ready) state_q <= IDLE;
        end
        SCR_RD: begin
          if (ecc_ready) begin
            data_q  <= ecc_rdata;
            state_q <= SCR_CHK;
          end
        end
        SCR_CHK: begin
          if (ecc_single_error) begin
            if (corr_q != 16'hFFFF) corr_q <= corr_q + 16'd1;
            last_q  <= scrub_addr_q;
            state_q <= SCR_WB;
          end else begin
            if (ecc_double_error) begin
              if (uncorr_q != 16'hFFFF) uncorr_q <= uncorr_q + 16'd1;
              last_q <= scrub_addr_q;
              irq_q  <= 1'b1;
            end
            state_q      <= IDLE;
            scrub_addr_q <= addr_nxt;
            pass_done_q  <= wrap;
          end
        end
        SCR_WB: begin
          if (ecc_ready) begin
            state_q      <= IDLE;
            scrub_addr_q <= addr_nxt;
            pass_done_q  <= wrap;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port mux: host inputs in HOST, scrub address/data otherwise
  always_comb begin
    ecc_req   = 1'b0;
    ecc_we    = 1'b0;
    ecc_addr  = '0;
    ecc_wdata = '0;
    case (state_q)
      HOST: begin
        ecc_req   = 1'b1;
        ecc_we    = host_we;
        ecc_addr  = host_addr;
        ecc_wdata = host_wdata;
      end
      SCR_RD: begin
        ecc_req  = 1'b1;
        ecc_addr = scrub_addr_q;
      end
      SCR_WB: begin
        ecc_req   = 1'b1;
        ecc_we    = 1'b1;
        ecc_addr  = scrub_addr_q;
        ecc_wdata = data_q;
      end
      default: ;
    endcase
  end

  assign host_ready    = (state_q == HOST) && ecc_ready;
  assign host_rdata    = (state_q == HOST) ? ecc_rdata : '0;
  assign scrub_busy    = busy;
  assign pass_done     = pass_done_q;
  assign corr_count    = corr_q;
  assign uncorr_count  = uncorr_q;
  assign last_err_addr = last_q;
  assign uncorr_irq    = irq_q;

`ifdef ECC_SCRUB_ERRLOG_EN
  logic [ADDR_WIDTH-1:0] log_q [4];
  logic [2:0]            wp_q;
  logic [2:0]            rp_q;
  logic [2:0]            fill;
  logic                  log_push;
  logic                  log_pop;

  assign fill     = wp_q - rp_q;
  assign log_push = (state_q == SCR_CHK) && !ecc_single_error
                 && ecc_double_error && (fill != 3'd4);
  assign log_pop  = errlog_pop && (fill != 3'd0);

  // Log pointers; a full log drops new entries, an empty pop is a no-op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (log_push) wp_q <= wp_q + 3'd1;
      if (log_pop)  rp_q <= rp_q + 3'd1;
    end
  end

  // Log storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (log_push) log_q[wp_q[1:0]] <= scrub_addr_q;
  end

  assign errlog_valid = fill != 3'd0;
  assign errlog_addr  = errlog_valid ? log_q[rp_q[1:0]] : '0;
`endif

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// tb_ecc_scrub_scheduler: scoreboard bench for the scrub scheduler.
// Expected memory accesses are queued per scenario and checked on each handshake.
module tb_ecc_scrub_scheduler;
  localparam int DW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_ready;
  logic          ecc_req, ecc_we;
  logic [AW-1:0] ecc_addr;
  logic [DW-1:0] ecc_wdata, ecc_rdata;
  logic          ecc_ready, ecc_single_error, ecc_double_error;
  logic          scrub_en;
  logic [15:0]   scrub_interval;
  logic [AW-1:0] scrub_base, scrub_limit;
  logic          scrub_busy, pass_done;
  logic [15:0]   corr_count, uncorr_count;
  logic [AW-1:0] last_err_addr;
  logic          uncorr_irq;
`ifdef ECC_SCRUB_ERRLOG_EN
  logic          errlog_pop, errlog_valid;
  logic [AW-1:0] errlog_addr;
`endif

  logic          inj_s_en, inj_d_en, inj_d_all;
  logic [AW-1:0] inj_s_addr, inj_d_addr;

  typedef struct packed {
    logic          we;
    logic          busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  acc_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   pd_cnt = 0;

  ecc_scrub_scheduler dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ready(host_ready),
    .ecc_req(ecc_req), .ecc_we(ecc_we), .ecc_addr(ecc_addr),
    .ecc_wdata(ecc_wdata), .ecc_rdata(ecc_rdata), .ecc_ready(ecc_ready),
    .ecc_single_error(ecc_single_error), .ecc_double_error(ecc_double_error),
    .scrub_en(scrub_en), .scrub_interval(scrub_interval),
    .scrub_base(scrub_base), .scrub_limit(scrub_limit),
    .scrub_busy(scrub_busy), .pass_done(pass_done),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .last_err_addr(last_err_addr), .uncorr_irq(uncorr_irq)
`ifdef ECC_SCRUB_ERRLOG_EN
    , .errlog_pop(errlog_pop), .errlog_valid(errlog_valid),
    .errlog_addr(errlog_addr)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic acc_t mk(input logic we, input logic busy,
                              input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    acc_t r;
    r.we = we;
    r.busy = busy;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  // ECC controller model: one-cycle ready, registered error flags
  assign ecc_rdata = rd_pat(ecc_addr);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecc_ready        <= 1'b0;
      ecc_single_error <= 1'b0;
      ecc_double_error <= 1'b0;
    end else begin
      ecc_ready <= ecc_req && !ecc_ready;
      ecc_single_error <= ecc_ready && ecc_req && !ecc_we && scrub_busy
                          && inj_s_en && ecc_addr == inj_s_addr;
      ecc_double_error <= ecc_ready && ecc_req && !ecc_we && scrub_busy
                          && (inj_d_all || (inj_d_en && ecc_addr == inj_d_addr));
    end
  end

  always @(negedge clk) if (pass_done) pd_cnt <= pd_cnt + 1;

  task automatic do_reset();
    rst = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    scrub_en = 1'b0; scrub_interval = '0; scrub_base = '0; scrub_limit = '0;
    inj_s_en = 1'b0; inj_d_en = 1'b0; inj_d_all = 1'b0;
    inj_s_addr = '0; inj_d_addr = '0;
`ifdef ECC_SCRUB_ERRLOG_EN
    errlog_pop = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_scrub(input logic [15:0] iv, input logic [AW-1:0] b,
                             input logic [AW-1:0] l);
    scrub_interval = iv;
    scrub_base = b;
    scrub_limit = l;
    scrub_en = 1'b1;
  endtask

  // Waits (bounded) for the next ECC handshake and captures it
  task automatic next_acc(output bit ok, output acc_t got, output logic hr,
                          output logic [DW-1:0] hrd, output int bad_hr);
    ok = 1'b0; got = '0; hr = 1'b0; hrd = '0; bad_hr = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (host_ready && scrub_busy) bad_hr++;
      if (ecc_req && ecc_ready) begin
        got = mk(ecc_we, scrub_busy, ecc_addr, ecc_wdata);
        hr = host_ready;
        hrd = host_rdata;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({ecc_req, ecc_we, host_ready, scrub_busy, pass_done, uncorr_irq} !== 6'b0)
      $display("FAIL reset_flags got %b need 000000",
               {ecc_req, ecc_we, host_ready, scrub_busy, pass_done, uncorr_irq});
    else n_pass++;
    n_total++;
    if (corr_count !== 16'd0) $display("FAIL reset_corr got %h need 0", corr_count);
    else n_pass++;
    n_total++;
    if (uncorr_count !== 16'd0) $display("FAIL reset_uncorr got %h need 0", uncorr_count);
    else n_pass++;
    n_total++;
    if (last_err_addr !== '0) $display("FAIL reset_last got %h need 0", last_err_addr);
    else n_pass++;
    n_total++;
    if (ecc_addr !== '0 || host_rdata !== '0)
      $display("FAIL reset_bus got addr=%h rdata=%h need 0", ecc_addr, host_rdata);
    else n_pass++;
  endtask

  task automatic test_host();
    bit ok; acc_t got, e; logic hr; logic [DW-1:0] hrd; int bad;
    do_reset();
    host_we = 1'b0; host_addr = 32'h100; host_req = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h100, '0));
    next_acc(ok, got, hr, hrd, bad);
    host_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (!ok || got.we !== e.we || got.addr !== e.addr || got.busy !== e.busy)
      $display("FAIL host_rd_acc got ok=%0b we=%b addr=%h need we=%b addr=%h",
               ok, got.we, got.addr, e.we, e.addr);
    else n_pass++;
    n_total++;
    if (hr !== 1'b1 || hrd !== rd_pat(32'h100))
      $display("FAIL host_rd_ready got rdy=%b data=%h need 1 %h", hr, hrd, rd_pat(32'h100));
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ecc_req !== 1'b0) $display("FAIL host_req_drop got %b need 0", ecc_req);
    else n_pass++;
    host_we = 1'b1; host_addr = 32'h108; host_wdata = 64'h1122_3344_5566_7788;
    host_req = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h108, 64'h1122_3344_5566_7788));
    next_acc(ok, got, hr, hrd, bad);
    host_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (!ok || got !== e || hr !== 1'b1)
      $display("FAIL host_wr_acc got ok=%0b rdy=%b acc=%h need %h", ok, hr, got, e);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_total++;
    if ({corr_count, uncorr_count, host_ready} !== 33'd0)
      $display("FAIL host_counts got corr=%h uncorr=%h rdy=%b need 0",
               corr_count, uncorr_count, host_ready);
    else n_pass++;
  endtask

  task automatic test_scrub_pass();
    bit ok; acc_t got, e; logic hr; logic [DW-1:0] hrd; int bad, pd0;
    do_reset();
    pd0 = pd_cnt;
    start_scrub(16'd4, 32'h0, 32'h10);
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h8, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h10, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h8, '0));
    while (exp_q.size() > 0) begin
      next_acc(ok, got, hr, hrd, bad);
      e = exp_q.pop_front();
      n_total++;
      if (!ok) begin
        $display("FAIL pass_acc timeout need addr=%h", e.addr);
        exp_q.delete();
      end else if (got.we !== e.we || got.addr !== e.addr || got.busy !== e.busy)
        $display("FAIL pass_acc got we=%b busy=%b addr=%h need we=%b busy=%b addr=%h",
                 got.we, got.busy, got.addr, e.we, e.busy, e.addr);
      else n_pass++;
    end
    n_total++;
    if (pd_cnt - pd0 !== 1) $display("FAIL pass_done_cnt got %0d need 1", pd_cnt - pd0);
    else n_pass++;
    n_total++;
    if (corr_count !== 16'd0 || uncorr_irq !== 1'b0)
      $display("FAIL pass_noerr got corr=%h irq=%b need 0 0", corr_count, uncorr_irq);
    else n_pass++;
    scrub_en = 1'b0;
  endtask

  task automatic test_single();
    bit ok; acc_t got, e; logic hr; logic [DW-1:0] hrd; int bad;
    do_reset();
    inj_s_en = 1'b1; inj_s_addr = 32'h8;
    start_scrub(16'd4, 32'h0, 32'h10);
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h8, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h8, rd_pat(32'h8)));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h10, '0));
    while (exp_q.size() > 0) begin
      next_acc(ok, got, hr, hrd, bad);
      e = exp_q.pop_front();
      n_total++;
      if (!ok) begin
        $display("FAIL single_acc timeout need addr=%h", e.addr);
        exp_q.delete();
      end else if (got.we !== e.we || got.addr !== e.addr || got.busy !== e.busy
                   || (e.we && got.data !== e.data))
        $display("FAIL single_acc got we=%b addr=%h data=%h need we=%b addr=%h data=%h",
                 got.we, got.addr, got.data, e.we, e.addr, e.data);
      else n_pass++;
    end
    n_total++;
    if (corr_count !== 16'd1 || uncorr_count !== 16'd0)
      $display("FAIL single_counts got corr=%h uncorr=%h need 1 0", corr_count, uncorr_count);
    else n_pass++;
    n_total++;
    if (last_err_addr !== 32'h8) $display("FAIL single_last got %h need 8", last_err_addr);
    else n_pass++;
    scrub_en = 1'b0; inj_s_en = 1'b0;
  endtask

  task automatic test_double();
    bit ok; acc_t got, e; logic hr; logic [DW-1:0] hrd; int bad;
    do_reset();
    inj_d_en = 1'b1; inj_d_addr = 32'h10;
    start_scrub(16'd4, 32'h0, 32'h10);
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h8, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h10, '0));
    exp_q.push_back(mk(1'b0, 1'b1, 32'h0, '0));
    while (exp_q.size() > 0) begin
      next_acc(ok, got, hr, hrd, bad);
      e = exp_q.pop_front();
      n_total++;
      if (!ok) begin
        $display("FAIL double_acc timeout need addr=%h", e.addr);
        exp_q.delete();
      end else if (got.we !== e.we || got.addr !== e.addr || got.busy !== e.busy)
        $display("FAIL double_acc got we=%b addr=%h need we=%b addr=%h",
                 got.we, got.addr, e.we, e.addr);
      else n_pass++;
    end
    inj_d_en = 1'b0;
    n_total++;
    if (uncorr_count !== 16'd1 || corr_count !== 16'd0 || uncorr_irq !== 1'b1)
      $display("FAIL double_counts got uncorr=%h corr=%h irq=%b need 1 0 1",
               uncorr_count, corr_count, uncorr_irq);
    else n_pass++;
    n_total++;
    if (last_err_addr !== 32'h10) $display("FAIL double_last got %h need 10", last_err_addr);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_total++;
    if (uncorr_irq !== 1'b1 || uncorr_count !== 16'd1)
      $display("FAIL double_sticky got irq=%b uncorr=%h need 1 1", uncorr_irq, uncorr_count);
    else n_pass++;
    scrub_en = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (uncorr_irq !== 1'b0) $display("FAIL irq_clear got %b need 0", uncorr_irq);
    else n_pass++;
  endtask

  task automatic test_starve();
    bit ok, seen; acc_t got, e; logic hr; logic [DW-1:0] hrd; int bad, bad_sum, hc;
    do_reset();
    host_we = 1'b0; host_addr = 32'h200; host_req = 1'b1;
    start_scrub(16'd0, 32'h40, 32'h40);
    hc = 0; seen = 1'b0; bad_sum = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (scrub_busy) seen = 1'b1;
      else if (ecc_req) hc++;
    end
    n_total++;
    if (!seen || hc < 64 || hc > 66)
      $display("FAIL starve_cycles got seen=%0b host_cycles=%0d need 64..66", seen, hc);
    else n_pass++;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h40, '0));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h200, '0));
    while (exp_q.size() > 0) begin
      next_acc(ok, got, hr, hrd, bad);
      bad_sum += bad;
      e = exp_q.pop_front();
      n_total++;
      if (!ok) begin
        $display("FAIL starve_acc timeout need addr=%h", e.addr);
        exp_q.delete();
      end else if (got.we !== e.we || got.addr !== e.addr || got.busy !== e.busy
                   || hr !== !e.busy)
        $display("FAIL starve_acc got busy=%b addr=%h rdy=%b need busy=%b addr=%h",
                 got.busy, got.addr, hr, e.busy, e.addr);
      else n_pass++;
    end
    host_req = 1'b0;
    scrub_en = 1'b0;
    n_total++;
    if (bad_sum !== 0) $display("FAIL host_wait got %0d early ready need 0", bad_sum);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    inj_d_all = 1'b1;
    start_scrub(16'd0, 32'h0, 32'h10);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (uncorr_count != 16'd0 && ecc_req && scrub_busy) ok = 1'b1;
    end
    rst = 1'b1;
    #1;
    n_total++;
    if (!ok || {ecc_req, scrub_busy, uncorr_irq, host_ready} !== 4'b0)
      $display("FAIL reset_mid got ok=%0b req=%b busy=%b irq=%b need 1 0 0 0",
               ok, ecc_req, scrub_busy, uncorr_irq);
    else n_pass++;
    n_total++;
    if (uncorr_count !== 16'd0 || last_err_addr !== '0)
      $display("FAIL reset_mid_regs got uncorr=%h last=%h need 0 0",
               uncorr_count, last_err_addr);
    else n_pass++;
    inj_d_all = 1'b0;
    scrub_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef ECC_SCRUB_ERRLOG_EN
  task automatic test_errlog();
    bit ok; logic [AW-1:0] lq[$]; logic [AW-1:0] a;
    do_reset();
    inj_d_all = 1'b1;
    start_scrub(16'd1, 32'h0, 32'h20);
    lq.push_back(32'h0); lq.push_back(32'h8);
    lq.push_back(32'h10); lq.push_back(32'h18);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (uncorr_count == 16'd5) ok = 1'b1;
    end
    scrub_en = 1'b0; inj_d_all = 1'b0;
    n_total++;
    if (!ok) $display("FAIL errlog_errors got uncorr=%h need 5", uncorr_count);
    else n_pass++;
    repeat (3) @(negedge clk);
    while (lq.size() > 0) begin
      a = lq.pop_front();
      n_total++;
      if (errlog_valid !== 1'b1 || errlog_addr !== a)
        $display("FAIL errlog_entry got v=%b addr=%h need 1 %h", errlog_valid, errlog_addr, a);
      else n_pass++;
      errlog_pop = 1'b1;
      @(negedge clk);
      errlog_pop = 1'b0;
    end
    n_total++;
    if (errlog_valid !== 1'b0) $display("FAIL errlog_empty got %b need 0", errlog_valid);
    else n_pass++;
    errlog_pop = 1'b1;
    @(negedge clk);
    errlog_pop = 1'b0;
    n_total++;
    if (errlog_valid !== 1'b0 || errlog_addr !== '0)
      $display("FAIL errlog_pop_empty got v=%b addr=%h need 0 0", errlog_valid, errlog_addr);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    scrub_en = 1'b0; scrub_interval = '0; scrub_base = '0; scrub_limit = '0;
    inj_s_en = 1'b0; inj_d_en = 1'b0; inj_d_all = 1'b0;
    inj_s_addr = '0; inj_d_addr = '0;
`ifdef ECC_SCRUB_ERRLOG_EN
    errlog_pop = 1'b0;
`endif
    test_reset();
    test_host();
    test_scrub_pass();
    test_single();
    test_double();
    test_starve();
    test_reset_mid();
`ifdef ECC_SCRUB_ERRLOG_EN
    test_errlog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_scheduler.md
Name: ecc_scrub_scheduler

Overview:
Sequencer and arbiter in front of the SECDED ECC controller's memory port. It shares that port between one host requester and a background scrub engine. The scrub engine periodically reads each word in a configured address window. When the ECC controller flags a single-bit error, the engine writes the corrected data back. It counts and logs correctable and uncorrectable errors, and raises an interrupt on uncorrectable ones.

Parameters:
DATA_WIDTH, 64, data word width (matches ECC controller)
ADDR_WIDTH, 32, byte address width
ADDR_STEP, 8, scrub address increment in bytes
STARVE_LIMIT, 64, cycles a pending scrub may be blocked by host traffic before it takes priority

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
host_req  in  1  host access request, held until host_ready
host_we  in  1  host write enable
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  DATA_WIDTH  host write data
host_rdata  out  DATA_WIDTH  host read data (pass-through of ecc_rdata)
host_ready  out  1  one-cycle host completion pulse
ecc_req  out  1  request to ECC controller
ecc_we  out  1  write enable to ECC controller
ecc_addr  out  ADDR_WIDTH  address to ECC controller
ecc_wdata  out  DATA_WIDTH  write data to ECC controller
ecc_rdata  in  DATA_WIDTH  corrected read data
ecc_ready  in  1  ECC controller completion
ecc_single_error  in  1  registered single-error flag, valid the cycle after read ecc_ready
ecc_double_error  in  1  registered double-error flag, same timing as ecc_single_error
scrub_en  in  1  scrub engine enable
scrub_interval  in  16  idle cycles between scrub accesses
scrub_base  in  ADDR_WIDTH  first scrub address
scrub_limit  in  ADDR_WIDTH  last scrub address, inclusive
scrub_busy  out  1  scrub sequence in progress
pass_done  out  1  one-cycle pulse when the window wraps
corr_count  out  16  corrected-error count, saturating
uncorr_count  out  16  uncorrectable-error count, saturating
last_err_addr  out  ADDR_WIDTH  address of the most recent error of either type
uncorr_irq  out  1  sticky; cleared only by reset or by scrub_en falling

Behaviour:
- Reset: every output is 0; FSM is IDLE; scrub_addr is 0; interval counter is 0; pending is 0; starve counter is 0.
- On a rising edge of scrub_en, scrub_addr loads scrub_base and the interval counter loads scrub_interval.
- Interval counter, while scrub_en=1 and not busy:
  - decrements each cycle;
  - at 0 it sets pending and reloads;
  - scrub_interval=0 gives back-to-back scrubs.
- FSM states: IDLE, HOST, SCR_RD, SCR_CHK, SCR_WB.
- IDLE arbitration:
  - host_req && !(pending && starve>=STARVE_LIMIT) -> HOST;
  - else pending -> SCR_RD;
  - host wins simultaneous requests unless the scrub is starved.
- Starve counter increments each cycle pending=1 and the FSM is in HOST. It clears when SCR_RD is entered.
- HOST state:
  - ecc_req/we/addr/wdata are driven from the host inputs;
  - on ecc_ready, host_ready=1 in the same cycle, then -> IDLE;
  - ecc_req deasserts the cycle after ecc_ready.
- SCR_RD state:
  - drives ecc_req=1, ecc_we=0, ecc_addr=scrub_addr;
  - on ecc_ready, captures ecc_rdata and clears pending, then -> SCR_CHK.
- SCR_CHK (one cycle) samples the error flags:
  - single_error: increment corr_count, set last_err_addr, -> SCR_WB;
  - double_error: increment uncorr_count, set last_err_addr, set uncorr_irq, no write-back, -> IDLE;
  - neither: -> IDLE.
- SCR_WB state:
  - drives ecc_we=1, ecc_addr=scrub_addr, ecc_wdata=captured data;
  - on ecc_ready -> IDLE.
- A scrub sequence (SCR_RD through SCR_WB) is atomic; host_req waits, with host_ready held low.
- scrub_addr advances by ADDR_STEP on leaving SCR_CHK (no error) or SCR_WB. If scrub_addr >= scrub_limit, it wraps to scrub_base and pulses pass_done.
- scrub_busy=1 in SCR_RD, SCR_CHK and SCR_WB.
- scrub_en falling mid-sequence: the sequence completes, then pending clears and no new scrub starts.
- Counters saturate at 16'hFFFF.
- Reset mid-transaction aborts immediately; outputs return to their reset values.

Optional Feature:
ECC_SCRUB_ERRLOG_EN:
- When defined, adds ports errlog_pop (in, 1), errlog_valid (out, 1) and errlog_addr (out, ADDR_WIDTH).
- Adds a 4-entry FIFO of uncorrectable-error addresses, pushed in SCR_CHK on double_error.
- A push when the FIFO is full drops the new entry.
- errlog_pop with the FIFO empty is ignored.
- Push and pop in the same cycle are both performed.
- When not defined, the ports and FIFO are absent and only last_err_addr is kept.

Test Plan:
- Host read at 0x100, scrub_en=0 -> ecc_req/addr=0x100 mirrored; host_ready pulses with ecc_ready; counts stay 0.
- scrub_en=1, interval=4, base=0x0, limit=0x10, no errors -> reads at 0x0, 0x8, 0x10, then 0x0; pass_done pulses once per wrap; no writes issued.
- single_error on scrub read of 0x8 -> write-back to 0x8 with the captured ecc_rdata; corr_count=1; last_err_addr=0x8.
- double_error on 0x10 -> no write; uncorr_count=1; uncorr_irq=1 and stays high; last_err_addr=0x10.
- host_req held continuously with interval=0 -> a scrub read issues after 64 blocked cycles; a host_req arriving in SCR_RD waits until the FSM returns to IDLE.
- Five double errors with ECC_SCRUB_ERRLOG_EN defined -> first 4 addresses logged in order, 5th dropped; 4 pops drain the FIFO and errlog_valid=0.
